// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and default widths for the Gray encoder/decoder pair.
package gray_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  localparam int MAX_W = 32;
  typedef logic [MAX_W-1:0] word_t;
  // Zero-extended upper bits stay zero through the prefix XOR, so one routine serves any WIDTH <= MAX_W.
  function automatic word_t gray2bin(word_t g);
    word_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic word_t bin2gray(word_t b);
    return b ^ (b >> 1);
  endfunction
  function automatic int unsigned popcount(word_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_W; i++) n = n + {31'b0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/gray_step_check.sv
// gray_step_check: flags accepted Gray words that move >=2 bits from the previous word; saturating flag counter.
module gray_step_check
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic [WIDTH-1:0] gray,
  input  logic             drain,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);
  logic [WIDTH-1:0] prev_gray;
  logic             prev_vld;
  assign err = prev_vld && (popcount(MAX_W'(gray ^ prev_gray)) > 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_gray <= '0;
      prev_vld  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (accept) begin
        prev_gray <= gray;
        prev_vld  <= 1'b1;
      end
      if (drain && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/gray_decoder.sv
// gray_decoder: two-stage valid/ready Gray-to-binary pipeline.
// Define GRAY_STEP_CHECK_EN to add per-word step-error flagging and a saturating error counter.
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);
  logic [WIDTH-1:0] s1_gray;
  logic             s1_valid;
  logic             s2_adv;
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_gray   <= '0;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_ready && in_valid) s1_gray <= in_data;
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) out_data <= WIDTH'(gray2bin(MAX_W'(s1_gray)));
    end
  end
`ifdef GRAY_STEP_CHECK_EN
  logic step_err;
  logic s1_err;
  gray_step_check #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_check (
    .clk     (clk),
    .rst_n   (rst_n),
    .accept  (in_valid && in_ready),
    .gray    (in_data),
    .drain   (out_valid && out_ready && out_err),
    .err     (step_err),
    .err_cnt (err_cnt)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_err  <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (in_ready && in_valid) s1_err <= step_err;
      if (s2_adv && s1_valid) out_err <= s1_err;
    end
  end
`else
  assign out_err = 1'b0;
  assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_gray_decoder.sv
// tb_gray_decoder: directed self-checking bench for gray_decoder (WIDTH=4, CNT_W=2).
module tb_gray_decoder;
  localparam int W = 4;
  localparam int CW = 2;
`ifdef GRAY_STEP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic [CW-1:0] err_cnt;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gray_decoder #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .err_cnt(err_cnt)
  );

  task automatic cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 4'b0101; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 4'h0 || err_cnt !== 2'd0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL reset[%0d]: out_valid=%b out_data=%h err_cnt=%0d in_ready=%b, want 0 0 0 1",
                 i, out_valid, out_data, err_cnt, in_ready);
      end
    end
    in_valid = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset_emit[%0d]: out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_sweep;
    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hc, 4'hd, 4'hf, 4'he, 4'ha, 4'hb, 4'h9, 4'h8};
    out_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      in_valid = (c < 16);
      in_data = (c < 16) ? gtab[c] : 4'h0;
      #1;
      if (c < 16) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL sweep_ready[%0d]: in_ready=%b want 1", c, in_ready);
        end
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (c >= 1 && c <= 16) begin
        if (out_valid !== 1'b1 || out_data !== 4'(c - 1)) begin
          failures++;
          $display("FAIL sweep[%0d]: out_valid=%b out_data=%h want 1 %h", c, out_valid, out_data, 4'(c - 1));
        end
      end else if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL sweep_idle[%0d]: out_valid=%b want 0", c, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [3:0] gtab [4] = '{4'h0, 4'h1, 4'h3, 4'h2};
    int idx = 0;
    int got = 0;
    bit acc;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid = (idx < 4);
      in_data = (idx < 4) ? gtab[idx] : 4'h0;
      #1;
      if (cyc >= 2 && cyc < 5) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 4'h0 || idx != 2) begin
          failures++;
          $display("FAIL bp_stall[%0d]: in_ready=%b out_valid=%b out_data=%h accepts=%0d want 0 1 0 2",
                   cyc, in_ready, out_valid, out_data, idx);
        end
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== 4'(got)) begin
          failures++;
          $display("FAIL bp_order[%0d]: out_data=%h want %h", got, out_data, 4'(got));
        end
        got++;
      end
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      if (got == 4) break;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4 || idx != 4 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain: drained=%0d accepted=%0d out_valid=%b want 4 4 0", got, idx, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'b0101;
    cycle;
    in_data = 4'b0110;
    cycle;
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rmid_full: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    cycle;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 4'h0) begin
      failures++;
      $display("FAIL rmid_reset: out_valid=%b in_ready=%b out_data=%h want 0 1 0", out_valid, in_ready, out_data);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 4'b0110;
    cycle;
    in_valid = 1'b0;
    cycle;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'b0100 || out_err !== 1'b0) begin
      failures++;
      $display("FAIL rmid_out: out_valid=%b out_data=%b out_err=%b want 1 0100 0", out_valid, out_data, out_err);
    end
    cycle;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_drop: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_step_check;
    logic [3:0] gdat [15] = '{4'h0, 4'h1, 4'h7, 4'h7, 4'h5, 4'h4, 4'hc, 4'h8,
                              4'h0, 4'h3, 4'h0, 4'h3, 4'h0, 4'h3, 4'h0};
    logic [3:0] bexp [15] = '{4'h0, 4'h1, 4'h5, 4'h5, 4'h6, 4'h7, 4'h8, 4'hf,
                              4'h0, 4'h2, 4'h0, 4'h2, 4'h0, 4'h2, 4'h0};
    logic       eexp [15] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    rst_n = 1'b0;
    cycle;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      in_valid = (c < 15);
      in_data = (c < 15) ? gdat[c] : 4'h0;
      cycle;
      if (c >= 1 && c <= 15) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== bexp[c-1] || out_err !== (eexp[c-1] & CHK)) begin
          failures++;
          $display("FAIL step[%0d]: out_valid=%b out_data=%h out_err=%b want 1 %h %b",
                   c - 1, out_valid, out_data, out_err, bexp[c-1], eexp[c-1] & CHK);
        end
      end
      if (c == 10) begin
        checks++;
        if (err_cnt !== (CHK ? 2'd1 : 2'd0)) begin
          failures++;
          $display("FAIL step_cnt_mid: err_cnt=%0d want %0d", err_cnt, CHK ? 1 : 0);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (err_cnt !== (CHK ? 2'd3 : 2'd0) || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL step_cnt_sat: err_cnt=%0d out_valid=%b want %0d 0", err_cnt, out_valid, CHK ? 3 : 0);
    end
  endtask

  initial begin
    test_reset;
    test_sweep;
    test_backpressure;
    test_reset_mid;
    test_step_check;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
